show_uart_tx: RTL

- Serialising end of the debug "show" interface: consumes the 128-bit `tx_show` frame and `show_len` byte count produced by the CPU top level.
- Transmits the frame as 8N1 UART bytes on a single `tx` line towards the host PC.
- Latches one frame per request and ignores the frame bus while sending.
- Counts requests it had to drop, so the host can detect lost trace records.

---
 rtl/show_uart_tx.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/show_uart_tx.sv
// Purpose: serialises a latched debug "show" frame (up to 16 bytes) as 8N1 UART on tx.
// Latency: tx drops to the start bit on the cycle after the accepting edge; each byte takes 10*CLKS_PER_BIT cycles.
// Backpressure: none; send_req while busy is discarded and counted in the saturating drop_cnt.
//
// Ports:
//   clk       system clock
//   reset     synchronous, active-high reset
//   tx_show   frame; the low show_len bytes are valid, byte show_len-1 goes out first
//   show_len  byte count (0 = nothing, >16 clamps to 16)
//   send_req  single-cycle request to send the current tx_show/show_len
//   tx        UART line, idle high
//   busy      frame in progress
//   done      one-cycle pulse after the last stop bit of a frame
//   drop_cnt  saturating count of requests dropped while busy
module show_uart_tx #(
    parameter int CLKS_PER_BIT = 868,
    parameter int CNT_W        = 10
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [127:0] tx_show,
    input  logic [4:0]   show_len,
    input  logic         send_req,
    output logic         tx,
    output logic         busy,
    output logic         done,
    output logic [7:0]   drop_cnt
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    state_t         state, state_n;
    logic [CNT_W-1:0] bit_cnt, bit_cnt_n;
    logic [2:0]     bit_idx, bit_idx_n;
    logic [4:0]     byte_cnt, byte_cnt_n;
    logic [127:0]   frame_q, frame_n;
    logic           tx_n, busy_n, done_n;

    logic [4:0]     eff_len;
    logic [3:0]     byte_sel;
    logic [7:0]     cur_byte;
    logic           bit_end;
    logic           accept;

    assign eff_len  = (show_len > 5'd16) ? 5'd16 : show_len;

    // The byte on the wire is the top remaining one: index byte_cnt-1.
    // Truncating to 4 bits keeps the part-select in range even when
    // byte_cnt is 0 in IDLE (the value is unused there).
    assign byte_sel = 4'(byte_cnt - 5'd1);
    assign cur_byte = frame_q[{byte_sel, 3'b000} +: 8];

    assign bit_end  = (bit_cnt == BIT_LAST);
    assign accept   = (state == IDLE) && send_req && (eff_len != 5'd0);

    always_comb begin
        state_n    = state;
        bit_cnt_n  = (state == IDLE || bit_end) ? '0 : bit_cnt + CNT_W'(1);
        bit_idx_n  = bit_idx;
        byte_cnt_n = byte_cnt;
        frame_n    = frame_q;
        tx_n       = tx;
        busy_n     = busy;
        done_n     = 1'b0;

        case (state)
            IDLE: begin
                tx_n = 1'b1;
                if (accept) begin
                    frame_n    = tx_show;
                    byte_cnt_n = eff_len;
                    bit_cnt_n  = '0;
                    tx_n       = 1'b0;
                    busy_n     = 1'b1;
                    state_n    = START;
                end
            end
            START: begin
                if (bit_end) begin
                    state_n   = DATA;
                    bit_idx_n = 3'd0;
                    tx_n      = cur_byte[0];
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (bit_idx == 3'd7) begin
                        state_n = STOP;
                        tx_n    = 1'b1;
                    end else begin
                        bit_idx_n = bit_idx + 3'd1;
                        tx_n      = cur_byte[bit_idx + 3'd1];
                    end
                end
            end
            STOP: begin
                if (bit_end) begin
                    byte_cnt_n = byte_cnt - 5'd1;
                    if (byte_cnt == 5'd1) begin
                        state_n = IDLE;
                        busy_n  = 1'b0;
                        done_n  = 1'b1;
                        tx_n    = 1'b1;
                    end else begin
                        // Next start bit follows the stop bit with no gap.
                        state_n = START;
                        tx_n    = 1'b0;
                    end
                end
            end
            default: begin
                state_n = IDLE;
                tx_n    = 1'b1;
                busy_n  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            bit_cnt  <= '0;
            bit_idx  <= 3'd0;
            byte_cnt <= 5'd0;
            frame_q  <= '0;
            tx       <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_n;
            bit_cnt  <= bit_cnt_n;
            bit_idx  <= bit_idx_n;
            byte_cnt <= byte_cnt_n;
            frame_q  <= frame_n;
            tx       <= tx_n;
            busy     <= busy_n;
            done     <= done_n;
        end
    end

    // Requests arriving in the done cycle see busy=0 and are accepted, not dropped.
    always_ff @(posedge clk) begin
        if (reset) begin
            drop_cnt <= 8'd0;
        end else if (busy && send_req && (drop_cnt != 8'hFF)) begin
            drop_cnt <= drop_cnt + 8'd1;
        end
    end

endmodule
